// File: rtl/rbi_mmu_acc_fault.sv
// rbi_mmu_acc_fault: downstream stage of the MMU access checker.
//
// A request is latched when accepted (stage A). One edge later the checker's
// NoRwx/exception result for that request is sampled and the final outcome is
// registered (stage B), so respValid appears two clocks after the request when
// nothing stalls it. A checker Hold bounces the request through a one-cycle
// RETRY state that asks upstream to re-present it. After RETRY_MAX retries the
// next Hold is reported as a timeout exception. The first faulting address and
// code are kept for the trap unit until acknowledged.
//
// Ports
//   clock_i, reset_ni   core clock, asynchronous active-low reset
//   regInHold_i         freezes every register while high
//   reqValid_i          request presented; reqAddr_i/reqKind_i/reqUser_i describe it
//   chkExc_i            checker exception code for the request in stage B
//   chkNoRwx_i          checker NoRwx {Hold, NU, NC, NX, NW, NR}, same timing
//   reqReady_o          a new request can be accepted this cycle
//   reqRetry_o          one-cycle pulse: upstream re-presents the aligned request
//   respValid_o         one-cycle result strobe with respOk_o/respNoCache_o/respExc_o
//   fault*_o            sticky first-fault record, cleared by faultAck_i
//
// Prefetches never fault: any condition that would fault a prefetch (including
// a read denial or a retry timeout) is reported as respOk=0, respExc=0.

module rbi_mmu_acc_fault #(
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned RETRY_MAX = 7
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              regInHold_i,
  input  logic              reqValid_i,
  input  logic [ADDR_W-1:0] reqAddr_i,
  input  logic [1:0]        reqKind_i,
  input  logic              reqUser_i,
  input  logic [15:0]       chkExc_i,
  input  logic [5:0]        chkNoRwx_i,
  output logic              reqReady_o,
  output logic              reqRetry_o,
  output logic              respValid_o,
  output logic              respOk_o,
  output logic              respNoCache_o,
  output logic [15:0]       respExc_o,
  output logic              faultValid_o,
  output logic              faultOverrun_o,
  output logic [ADDR_W-1:0] faultAddr_o,
  output logic [15:0]       faultExc_o,
  input  logic              faultAck_i
);

  localparam logic [1:0] KindLoad     = 2'b00;
  localparam logic [1:0] KindStore    = 2'b01;
  localparam logic [1:0] KindIfetch   = 2'b10;
  localparam logic [1:0] KindPrefetch = 2'b11;

  localparam logic [15:0] ExcLoad    = 16'hA001;
  localparam logic [15:0] ExcStore   = 16'hA003;
  localparam logic [15:0] ExcIfetch  = 16'hA004;
  localparam logic [15:0] ExcUser    = 16'hA005;
  localparam logic [15:0] ExcTimeout = 16'hA00F;

  localparam logic [3:0] RetryMax = 4'(RETRY_MAX);

  typedef enum logic [1:0] {StIdle, StChk, StRetry} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        kind_q, kind_d;
  logic              user_q, user_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic              retry_q, retry_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_ok_q, resp_ok_d;
  logic              resp_nc_q, resp_nc_d;
  logic [15:0]       resp_exc_q, resp_exc_d;
  logic              fault_valid_q, fault_valid_d;
  logic              fault_overrun_q, fault_overrun_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [15:0]       fault_exc_q, fault_exc_d;

  logic        hold_hit, timeout, do_retry;
  logic        req_ready, accept, chk_now, deliver, fault_hit;
  logic [15:0] raw_exc, eval_exc;
  logic        eval_ok;

  // Hold from the checker only bounces the request while retries remain.
  assign hold_hit = chkNoRwx_i[5];
  assign timeout  = hold_hit && (retry_cnt_q == RetryMax);
  assign do_retry = hold_hit && !timeout;

  // Stage B frees the latch in the same cycle it delivers, allowing 1 req/clk.
  assign req_ready = (state_q == StIdle) || ((state_q == StChk) && !do_retry);
  assign accept    = reqValid_i && req_ready && !regInHold_i;
  assign chk_now   = (state_q == StChk) && !regInHold_i;
  assign deliver   = chk_now && !do_retry;

  // Outcome of the latched request against this cycle's checker result.
  always_comb begin
    raw_exc = '0;
    if (timeout) begin
      raw_exc = ExcTimeout;
    end else if (chkExc_i != '0) begin
      raw_exc = chkExc_i;
    end else if (user_q && chkNoRwx_i[4]) begin
      raw_exc = ExcUser;
    end else begin
      unique case (kind_q)
        KindLoad:     if (chkNoRwx_i[0]) raw_exc = ExcLoad;
        KindStore:    if (chkNoRwx_i[1]) raw_exc = ExcStore;
        KindIfetch:   if (chkNoRwx_i[2]) raw_exc = ExcIfetch;
        // Prefetch is a read probe: a read denial only squashes it.
        KindPrefetch: if (chkNoRwx_i[0]) raw_exc = ExcLoad;
      endcase
    end

    eval_ok = (raw_exc == '0);
    if (kind_q == KindPrefetch) begin
      eval_exc = '0;
    end else begin
      eval_exc = raw_exc;
    end
  end

  assign fault_hit = deliver && (eval_exc != '0);

  // Next-state logic; everything is committed only when regInHold_i is low.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    kind_d          = kind_q;
    user_d          = user_q;
    retry_cnt_d     = retry_cnt_q;
    retry_d         = 1'b0;
    resp_valid_d    = deliver;
    resp_ok_d       = deliver && eval_ok;
    resp_nc_d       = deliver && chkNoRwx_i[3];
    resp_exc_d      = deliver ? eval_exc : 16'h0000;
    fault_valid_d   = fault_valid_q;
    fault_overrun_d = fault_overrun_q;
    fault_addr_d    = fault_addr_q;
    fault_exc_d     = fault_exc_q;

    if (accept) begin
      addr_d = reqAddr_i;
      kind_d = reqKind_i;
      user_d = reqUser_i;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StChk;
      end
      StChk: begin
        if (do_retry) begin
          state_d = StRetry;
          retry_d = 1'b1;
        end else begin
          state_d     = accept ? StChk : StIdle;
          retry_cnt_d = '0;
        end
      end
      StRetry: begin
        state_d     = StChk;
        retry_cnt_d = retry_cnt_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase

    // An acknowledge in the same cycle as a new fault drops the new fault.
    if (faultAck_i) begin
      fault_valid_d   = 1'b0;
      fault_overrun_d = 1'b0;
      fault_addr_d    = '0;
      fault_exc_d     = '0;
    end else if (fault_hit) begin
      if (!fault_valid_q) begin
        fault_valid_d = 1'b1;
        fault_addr_d  = addr_q;
        fault_exc_d   = eval_exc;
      end else begin
        fault_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      kind_q          <= '0;
      user_q          <= 1'b0;
      retry_cnt_q     <= '0;
      retry_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_ok_q       <= 1'b0;
      resp_nc_q       <= 1'b0;
      resp_exc_q      <= '0;
      fault_valid_q   <= 1'b0;
      fault_overrun_q <= 1'b0;
      fault_addr_q    <= '0;
      fault_exc_q     <= '0;
    end else if (!regInHold_i) begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      kind_q          <= kind_d;
      user_q          <= user_d;
      retry_cnt_q     <= retry_cnt_d;
      retry_q         <= retry_d;
      resp_valid_q    <= resp_valid_d;
      resp_ok_q       <= resp_ok_d;
      resp_nc_q       <= resp_nc_d;
      resp_exc_q      <= resp_exc_d;
      fault_valid_q   <= fault_valid_d;
      fault_overrun_q <= fault_overrun_d;
      fault_addr_q    <= fault_addr_d;
      fault_exc_q     <= fault_exc_d;
    end
  end

  assign reqReady_o     = req_ready;
  assign reqRetry_o     = retry_q;
  assign respValid_o    = resp_valid_q;
  assign respOk_o       = resp_ok_q;
  assign respNoCache_o  = resp_nc_q;
  assign respExc_o      = resp_exc_q;
  assign faultValid_o   = fault_valid_q;
  assign faultOverrun_o = fault_overrun_q;
  assign faultAddr_o    = fault_addr_q;
  assign faultExc_o     = fault_exc_q;

endmodule

// File: tb/tb_rbi_mmu_acc_fault.sv
// Bench for rbi_mmu_acc_fault. Directed transactions push their expected
// outcome (from a rule-level model) and due cycle into queues; one compare
// process checks every output on every negedge against those queues and a
// small fault-record model. Hand-computed literals pin the model.

module tb_rbi_mmu_acc_fault;

  localparam int AW   = 48;
  localparam int RMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_kind = '0;
  logic          req_user = 1'b0;
  logic [15:0]   chk_exc = '0;
  logic [5:0]    chk_nrwx = '0;
  logic          fault_ack = 1'b0;

  logic          req_ready, req_retry, resp_valid, resp_ok, resp_nc;
  logic [15:0]   resp_exc, fault_exc;
  logic          fault_valid, fault_overrun;
  logic [AW-1:0] fault_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int retry_seen = 0;

  typedef struct {
    int            due;
    logic          ok;
    logic [15:0]   exc;
    logic          nc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   ret_q[$];

  rbi_mmu_acc_fault #(.ADDR_W(AW), .RETRY_MAX(RMAX)) dut (
    .clock_i        (clk),
    .reset_ni       (rst_n),
    .regInHold_i    (hold),
    .reqValid_i     (req_valid),
    .reqAddr_i      (req_addr),
    .reqKind_i      (req_kind),
    .reqUser_i      (req_user),
    .chkExc_i       (chk_exc),
    .chkNoRwx_i     (chk_nrwx),
    .reqReady_o     (req_ready),
    .reqRetry_o     (req_retry),
    .respValid_o    (resp_valid),
    .respOk_o       (resp_ok),
    .respNoCache_o  (resp_nc),
    .respExc_o      (resp_exc),
    .faultValid_o   (fault_valid),
    .faultOverrun_o (fault_overrun),
    .faultAddr_o    (fault_addr),
    .faultExc_o     (fault_exc),
    .faultAck_i     (fault_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Access rules, first match wins; prefetches are squashed, never faulted.
  function automatic void model(input logic [1:0] kind, input logic user,
                                input logic [15:0] exc, input logic [5:0] nrwx,
                                input logic tmo, output logic ok, output logic [15:0] rexc);
    logic [15:0] e;
    e = 16'h0;
    if (tmo) e = 16'hA00F;
    else if (exc != 16'h0) e = exc;
    else if (user && nrwx[4]) e = 16'hA005;
    else if ((kind == 2'd0 || kind == 2'd3) && nrwx[0]) e = 16'hA001;
    else if (kind == 2'd1 && nrwx[1]) e = 16'hA003;
    else if (kind == 2'd2 && nrwx[2]) e = 16'hA004;
    ok   = (e == 16'h0);
    rexc = (kind == 2'd3) ? 16'h0 : e;
  endfunction

  task automatic push_exp(input int due, input logic [1:0] kind, input logic user,
                          input logic [AW-1:0] addr, input logic [15:0] exc,
                          input logic [5:0] nrwx, input logic tmo);
    exp_t x;
    model(kind, user, exc, nrwx, tmo, x.ok, x.exc);
    x.due  = due;
    x.nc   = nrwx[3];
    x.addr = addr;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; the first `holds` checks report Hold.
  task automatic txn(input logic [1:0] kind, input logic user, input logic [AW-1:0] addr,
                     input logic [15:0] exc, input logic [5:0] nrwx, input int holds);
    req_valid = 1'b1;
    req_kind  = kind;
    req_user  = user;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= RMAX; i++) begin
      logic h;
      h = (i < holds);
      chk_exc  = exc;
      chk_nrwx = {h, nrwx[4:0]};
      if (h && i < RMAX) begin
        ret_q.push_back(cyc + 1);
        tick();
        chk_exc  = '0;
        chk_nrwx = '0;
        tick();
      end else begin
        push_exp(cyc + 1, kind, user, addr, exc, nrwx, h);
        tick();
        break;
      end
    end
    chk_exc  = '0;
    chk_nrwx = '0;
  endtask

  task automatic ack();
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
  endtask

  // Compare process: expected outputs of every cycle.
  logic          e_valid = 0, e_ok = 0, e_nc = 0, e_retry = 0;
  logic [15:0]   e_exc = '0;
  logic          m_fv = 0, m_fo = 0;
  logic [AW-1:0] m_fa = '0;
  logic [15:0]   m_fe = '0;

  initial begin
    logic ack_s, hold_s, fault_now;
    logic [AW-1:0] fault_a;
    forever begin
      @(posedge clk);
      cyc++;
      ack_s  = fault_ack;
      hold_s = hold;
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        ret_q.delete();
        {e_valid, e_ok, e_nc, e_retry, m_fv, m_fo} = '0;
        e_exc = '0;
        m_fa  = '0;
        m_fe  = '0;
        chk("rst respValid", resp_valid, 0);
        chk("rst reqRetry", req_retry, 0);
        chk("rst reqReady", req_ready, 1);
        chk("rst faultValid", fault_valid, 0);
        continue;
      end
      if (!hold_s) begin
        fault_now = 1'b0;
        fault_a   = '0;
        e_valid = 0; e_ok = 0; e_nc = 0; e_exc = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          exp_t x;
          x = exp_q.pop_front();
          e_valid = 1; e_ok = x.ok; e_nc = x.nc; e_exc = x.exc;
          fault_now = (x.exc != 16'h0);
          fault_a   = x.addr;
        end
        e_retry = 0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
          void'(ret_q.pop_front());
          e_retry = 1;
        end
        if (ack_s) begin
          m_fv = 0; m_fo = 0; m_fa = '0; m_fe = '0;
        end else if (fault_now) begin
          if (!m_fv) begin
            m_fv = 1; m_fa = fault_a; m_fe = e_exc;
          end else begin
            m_fo = 1;
          end
        end
      end
      if (req_retry) retry_seen++;
      chk("respValid", resp_valid, e_valid);
      chk("respOk", resp_ok, e_ok);
      chk("respExc", resp_exc, e_exc);
      chk("respNoCache", resp_nc, e_nc);
      chk("reqRetry", req_retry, e_retry);
      if (e_retry) chk("reqReady in RETRY", req_ready, 0);
      chk("faultValid", fault_valid, m_fv);
      chk("faultOverrun", fault_overrun, m_fo);
      chk("faultAddr", fault_addr, m_fa);
      chk("faultExc", fault_exc, m_fe);
    end
  end

  typedef struct {
    logic [1:0]  k;
    logic        u;
    logic [15:0] e;
    logic [5:0]  n;
    logic        ok;
    logic [15:0] rexc;
  } vec_t;

  vec_t vecs[6] = '{
    '{2'd0, 1'b1, 16'h0, 6'b010000, 1'b0, 16'hA005},  // user load on supervisor page
    '{2'd0, 1'b0, 16'h0, 6'b000001, 1'b0, 16'hA001},  // load NR
    '{2'd2, 1'b0, 16'h0, 6'b000100, 1'b0, 16'hA004},  // ifetch NX
    '{2'd3, 1'b1, 16'h0, 6'b010001, 1'b0, 16'h0000},  // denied prefetch
    '{2'd1, 1'b0, 16'h0, 6'b001000, 1'b1, 16'h0000},  // store, non-cacheable
    '{2'd2, 1'b1, 16'h0, 6'b000011, 1'b1, 16'h0000}   // ifetch, NR/NW irrelevant
  };

  initial begin
    int r0;
    logic [AW-1:0] a1, a2, a3;
    a1 = 48'h0000_0000_1000;
    a2 = 48'h0000_0000_2000;
    a3 = 48'h0000_0000_3000;

    // Reset
    repeat (2) tick();
    chk("reset reqReady", req_ready, 1);
    chk("reset respExc", resp_exc, 0);
    chk("reset faultAddr", fault_addr, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // T1 plain load
    txn(2'd0, 1'b0, 48'h0000_0000_0040, 16'h0, 6'b000000, 0);
    chk("T1 respValid", resp_valid, 1);
    chk("T1 respOk", resp_ok, 1);
    chk("T1 respExc", resp_exc, 0);
    chk("T1 faultValid", fault_valid, 0);
    tick();

    // T2 store to a non-writable page
    txn(2'd1, 1'b0, 48'h0000_1234_5000, 16'h0, 6'b000010, 0);
    chk("T2 respExc", resp_exc, 16'hA003);
    chk("T2 faultAddr", fault_addr, 48'h0000_1234_5000);
    chk("T2 faultValid", fault_valid, 1);
    ack();
    chk("T2 ack faultValid", fault_valid, 0);

    // T3 checker exception wins over NX
    txn(2'd2, 1'b0, 48'h0000_0000_8000, 16'hA002, 6'b000100, 0);
    chk("T3 respExc", resp_exc, 16'hA002);
    chk("T3 faultExc", fault_exc, 16'hA002);
    ack();

    // Rule table
    foreach (vecs[i]) begin
      txn(vecs[i].k, vecs[i].u, 48'(64'h100 * (i + 1)), vecs[i].e, vecs[i].n, 0);
      chk("VEC respOk", resp_ok, vecs[i].ok);
      chk("VEC respExc", resp_exc, vecs[i].rexc);
      if (vecs[i].k == 2'd3) chk("VEC prefetch no capture", fault_valid, 0);
      ack();
    end

    // T4 retries, then timeout
    r0 = retry_seen;
    txn(2'd0, 1'b0, 48'h0000_0000_A000, 16'h0, 6'b000000, 3);
    chk("T4 retry pulses", retry_seen - r0, 3);
    chk("T4 respOk", resp_ok, 1);
    tick();
    r0 = retry_seen;
    txn(2'd0, 1'b0, 48'h0000_0000_B000, 16'h0, 6'b000000, RMAX + 1);
    chk("T4 timeout pulses", retry_seen - r0, RMAX);
    chk("T4 timeout respExc", resp_exc, 16'hA00F);
    ack();

    // T5 back-to-back faulting loads, ack colliding with a third fault
    req_valid = 1'b1;
    req_kind  = 2'd0;
    req_user  = 1'b0;
    req_addr  = a1;
    tick();
    req_addr = a2;
    chk_nrwx = 6'b000001;
    chk("T5 back-to-back reqReady", req_ready, 1);
    push_exp(cyc + 1, 2'd0, 1'b0, a1, 16'h0, 6'b000001, 1'b0);
    tick();
    chk("T5 first faultAddr", fault_addr, a1);
    req_addr = a3;
    push_exp(cyc + 1, 2'd0, 1'b0, a2, 16'h0, 6'b000001, 1'b0);
    tick();
    chk("T5 keep faultAddr", fault_addr, a1);
    chk("T5 faultOverrun", fault_overrun, 1);
    req_valid = 1'b0;
    fault_ack = 1'b1;
    push_exp(cyc + 1, 2'd0, 1'b0, a3, 16'h0, 6'b000001, 1'b0);
    tick();
    fault_ack = 1'b0;
    chk_nrwx  = '0;
    chk("T5 third respExc", resp_exc, 16'hA001);
    chk("T5 ack faultValid", fault_valid, 0);
    chk("T5 ack faultOverrun", fault_overrun, 0);
    chk("T5 ack faultExc", fault_exc, 0);
    repeat (2) tick();

    // T6 hold for 4 clocks in CHK
    req_valid = 1'b1;
    req_kind  = 2'd1;
    req_addr  = 48'h0000_0000_C000;
    tick();
    req_valid = 1'b0;
    chk_nrwx  = 6'b001000;
    hold      = 1'b1;
    repeat (4) tick();
    hold = 1'b0;
    chk("T6 no resp during hold", resp_valid, 0);
    push_exp(cyc + 1, 2'd1, 1'b0, 48'h0000_0000_C000, 16'h0, 6'b001000, 1'b0);
    tick();
    chk_nrwx = '0;
    chk("T6 delayed respValid", resp_valid, 1);
    chk("T6 respNoCache", resp_nc, 1);
    // A pending respValid stays high while held
    hold = 1'b1;
    repeat (2) tick();
    chk("T6 held respValid", resp_valid, 1);
    hold = 1'b0;
    tick();
    chk("T6 released respValid", resp_valid, 0);

    // T6 reset while in RETRY
    req_valid = 1'b1;
    req_kind  = 2'd0;
    req_addr  = 48'h0000_0000_D000;
    tick();
    req_valid = 1'b0;
    chk_nrwx  = 6'b100000;
    ret_q.push_back(cyc + 1);
    tick();
    chk_nrwx = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("T6 reset reqRetry", req_retry, 0);
    chk("T6 reset reqReady", req_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    chk("no pending responses", exp_q.size(), 0);
    chk("no pending retries", ret_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
